mem_access_stage: RTL and testbench

- MEM pipeline stage, directly downstream of the EX-stage ALU.
- Consumes the ALU result (effective address or arithmetic result), the store operand and control bits.
- Performs load/store on a request/ready data-memory port, with byte/half/word lane steering and sign/zero extension.
- Registers the result toward write-back, and stalls upstream while a memory access is outstanding.

---
 rtl/mem_access_stage_pkg.sv | 41 ++++
 rtl/mem_access_stage_load_extend.sv | 29 ++
 rtl/mem_access_stage.sv | 205 ++++++++++++++++++++
 tb/tb_mem_access_stage.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared constants for the MEM stage: funct3 access encodings, FSM states and
// data-memory strobe width, plus small decode helpers.
package mem_access_stage_pkg;

    localparam int DMEM_STRB_WIDTH = 4;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_t;

    // Reserved encodings fall through to a word access.
    function automatic size_t access_size(input logic [2:0] funct3);
        case (funct3)
            F3_B, F3_BU: return SZ_BYTE;
            F3_H, F3_HU: return SZ_HALF;
            default:     return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] off);
        case (access_size(funct3))
            SZ_HALF: return off[0];
            SZ_WORD: return off != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/mem_access_stage_load_extend.sv
// Load lane extraction: pick the byte/half addressed by addr_lo out of the
// read word and sign- or zero-extend it according to funct3.
module load_extend
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            addr_lo,
    input  logic [2:0]            funct3,
    output logic [DATA_WIDTH-1:0] data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b = rdata[{addr_lo, 3'b000} +: 8];
        lane_h = rdata[{addr_lo[1], 4'b0000} +: 16];
        case (funct3)
            F3_B:    data = {{(DATA_WIDTH-8){lane_b[7]}}, lane_b};
            F3_BU:   data = {{(DATA_WIDTH-8){1'b0}}, lane_b};
            F3_H:    data = {{(DATA_WIDTH-16){lane_h[15]}}, lane_h};
            F3_HU:   data = {{(DATA_WIDTH-16){1'b0}}, lane_h};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: drives the request/ready data-memory port and registers
// results toward write-back. Optional access timeout via `define MEM_TIMEOUT_EN.
//
// state     | meaning
// ST_IDLE   | accept from EX; ALU ops and misaligned accesses retire next edge
// ST_ACCESS | memory request outstanding, dmem_* held, stall until dmem_ready
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       ex_valid,
    input  logic [DATA_WIDTH-1:0]      ex_alu_result,
    input  logic [DATA_WIDTH-1:0]      ex_store_data,
    input  logic                       ex_mem_read,
    input  logic                       ex_mem_write,
    input  logic [2:0]                 ex_funct3,
    input  logic [REG_ADDR_WIDTH-1:0]  ex_rd,
    input  logic                       ex_reg_write,
    output logic                       mem_stall,
    output logic                       dmem_req,
    output logic                       dmem_we,
    output logic [ADDR_WIDTH-1:0]      dmem_addr,
    output logic [DATA_WIDTH-1:0]      dmem_wdata,
    output logic [DMEM_STRB_WIDTH-1:0] dmem_wstrb,
    input  logic                       dmem_ready,
    input  logic [DATA_WIDTH-1:0]      dmem_rdata,
    output logic                       wb_valid,
    output logic [DATA_WIDTH-1:0]      wb_data,
    output logic [REG_ADDR_WIDTH-1:0]  wb_rd,
    output logic                       wb_reg_write,
`ifdef MEM_TIMEOUT_EN
    output logic                       bus_error,
`endif
    output logic                       misalign
);

    state_t state, state_next;

    logic                      is_mem;
    logic                      is_store;
    logic [1:0]                off;
    logic                      bad_align;
    logic                      start;
    logic [ADDR_WIDTH-1:0]     addr_full;
    logic [DATA_WIDTH-1:0]     st_wdata;
    logic [DMEM_STRB_WIDTH-1:0] st_strb;
    logic [DATA_WIDTH-1:0]     ld_data;

    logic                      acc_load;
    logic [2:0]                acc_funct3;
    logic [1:0]                acc_off;
    logic [REG_ADDR_WIDTH-1:0] acc_rd;
    logic                      acc_reg_write;

    assign is_mem    = ex_mem_read | ex_mem_write;
    assign is_store  = ex_mem_write;
    assign off       = ex_alu_result[1:0];
    assign bad_align = is_mem && is_misaligned(ex_funct3, off);
    assign start     = (state == ST_IDLE) && ex_valid && is_mem && !bad_align;
    assign addr_full = ADDR_WIDTH'(ex_alu_result);

`ifdef MEM_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES) > 8) ? $clog2(TIMEOUT_CYCLES) : 8;
    logic [CNT_W-1:0] wait_cnt;
    logic             expire;
    assign expire = (state == ST_ACCESS) && !dmem_ready &&
                    (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    always_comb begin
        st_strb  = {DMEM_STRB_WIDTH{1'b1}};
        st_wdata = ex_store_data;
        case (access_size(ex_funct3))
            SZ_BYTE: begin
                st_strb  = DMEM_STRB_WIDTH'(1) << off;
                st_wdata = {(DATA_WIDTH/8){ex_store_data[7:0]}};
            end
            SZ_HALF: begin
                st_strb  = DMEM_STRB_WIDTH'(3) << off;
                st_wdata = {(DATA_WIDTH/16){ex_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    load_extend #(.DATA_WIDTH(DATA_WIDTH)) u_load_extend (
        .rdata   (dmem_rdata),
        .addr_lo (acc_off),
        .funct3  (acc_funct3),
        .data    (ld_data)
    );

    always_comb begin
        state_next = state;
        mem_stall  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_ACCESS;
                    mem_stall  = 1'b1;
                end
            end
            ST_ACCESS: begin
                mem_stall = !dmem_ready;
                if (dmem_ready) state_next = ST_IDLE;
`ifdef MEM_TIMEOUT_EN
                if (expire) begin
                    state_next = ST_IDLE;
                    mem_stall  = 1'b0;
                end
`endif
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= ST_IDLE;
            wb_valid      <= 1'b0;
            wb_data       <= '0;
            wb_rd         <= '0;
            wb_reg_write  <= 1'b0;
            misalign      <= 1'b0;
            dmem_req      <= 1'b0;
            dmem_we       <= 1'b0;
            dmem_addr     <= '0;
            dmem_wdata    <= '0;
            dmem_wstrb    <= '0;
            acc_load      <= 1'b0;
            acc_funct3    <= '0;
            acc_off       <= '0;
            acc_rd        <= '0;
            acc_reg_write <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            wait_cnt      <= '0;
            bus_error     <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            wb_valid <= 1'b0;
            misalign <= 1'b0;
`ifdef MEM_TIMEOUT_EN
            bus_error <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (ex_valid && !is_mem) begin
                        wb_valid     <= 1'b1;
                        wb_data      <= ex_alu_result;
                        wb_rd        <= ex_rd;
                        wb_reg_write <= ex_reg_write;
                    end else if (ex_valid && bad_align) begin
                        wb_valid     <= 1'b1;
                        wb_data      <= ex_alu_result;
                        wb_rd        <= ex_rd;
                        wb_reg_write <= 1'b0;
                        misalign     <= 1'b1;
                    end else if (start) begin
                        dmem_req      <= 1'b1;
                        dmem_we       <= is_store;
                        dmem_addr     <= {addr_full[ADDR_WIDTH-1:2], 2'b00};
                        dmem_wdata    <= st_wdata;
                        dmem_wstrb    <= st_strb;
                        acc_load      <= !is_store;
                        acc_funct3    <= ex_funct3;
                        acc_off       <= off;
                        acc_rd        <= ex_rd;
                        acc_reg_write <= ex_reg_write & !is_store;
`ifdef MEM_TIMEOUT_EN
                        wait_cnt      <= '0;
`endif
                    end
                end
                ST_ACCESS: begin
                    if (dmem_ready) begin
                        dmem_req     <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_rd        <= acc_rd;
                        wb_reg_write <= acc_reg_write;
                        if (acc_load) wb_data <= ld_data;
`ifdef MEM_TIMEOUT_EN
                    end else if (expire) begin
                        dmem_req     <= 1'b0;
                        wb_valid     <= 1'b1;
                        wb_rd        <= acc_rd;
                        wb_reg_write <= 1'b0;
                        bus_error    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage; the timeout scenario is built only
// when MEM_TIMEOUT_EN is defined (instance uses TIMEOUT_CYCLES=4).
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        wb_valid;
    logic [31:0] wb_data;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic        misalign;
`ifdef MEM_TIMEOUT_EN
    logic        bus_error;
`endif

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        rw;
        logic        mis;
        logic        chk_data;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    mem_access_stage #(
        .DATA_WIDTH(32), .ADDR_WIDTH(32), .REG_ADDR_WIDTH(5), .TIMEOUT_CYCLES(4)
    ) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .mem_stall(mem_stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_wstrb(dmem_wstrb), .dmem_ready(dmem_ready),
        .dmem_rdata(dmem_rdata), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_reg_write(wb_reg_write),
`ifdef MEM_TIMEOUT_EN
        .bus_error(bus_error),
`endif
        .misalign(misalign)
    );

    // Retirement monitor: every wb_valid must match the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1 && wb_valid === 1'b1) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL wb_unexpected: wb_valid with empty scoreboard, wb_data=%h wb_rd=%0d", wb_data, wb_rd);
                end else begin
                    e = sb.pop_front();
                    if (wb_rd !== e.rd || wb_reg_write !== e.rw || misalign !== e.mis ||
                        (e.chk_data && wb_data !== e.data)) begin
                        errors++;
                        $display("FAIL wb_retire: got data=%h rd=%0d rw=%b mis=%b, want data=%h(chk=%b) rd=%0d rw=%b mis=%b",
                                 wb_data, wb_rd, wb_reg_write, misalign, e.data, e.chk_data, e.rd, e.rw, e.mis);
                    end
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                         input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [4:0] rd, input logic rw);
        ex_valid      = v;
        ex_alu_result = alu;
        ex_store_data = sd;
        ex_mem_read   = rd_en;
        ex_mem_write  = wr_en;
        ex_funct3     = f3;
        ex_rd         = rd;
        ex_reg_write  = rw;
    endtask

    task automatic push(input logic [31:0] d, input logic [4:0] rd, input logic rw,
                        input logic mis, input logic chk);
        exp_t e;
        e.data = d; e.rd = rd; e.rw = rw; e.mis = mis; e.chk_data = chk;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        drive(1'b0, '0, '0, 1'b0, 1'b0, 3'b000, '0, 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if ({wb_valid, wb_data, wb_rd, wb_reg_write, misalign, dmem_req, dmem_we,
             dmem_addr, dmem_wdata, dmem_wstrb} !== '0) begin
            errors++;
            $display("FAIL reset_regs: wb_valid=%b wb_data=%h wb_rd=%0d rw=%b mis=%b req=%b we=%b addr=%h wdata=%h strb=%b, want all 0",
                     wb_valid, wb_data, wb_rd, wb_reg_write, misalign, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb);
        end
        checks++;
        if (mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL reset_stall: mem_stall=%b want 0", mem_stall);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu_op();
        @(negedge clk);
        drive(1'b1, 32'h0000_1234, 32'h0, 1'b0, 1'b0, 3'b000, 5'd5, 1'b1);
        push(32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b1);
        #1;
        checks++;
        if (mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL alu_stall: mem_stall=%b want 0", mem_stall);
        end
        @(negedge clk);
        ex_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (wb_valid !== 1'b0 || wb_data !== 32'h0000_1234 || wb_rd !== 5'd5) begin
            errors++;
            $display("FAIL idle_hold: wb_valid=%b wb_data=%h wb_rd=%0d want 0/00001234/5", wb_valid, wb_data, wb_rd);
        end
    endtask

    task automatic test_load(input string name, input logic [2:0] f3, input logic [31:0] addr,
                             input logic [31:0] rdata, input int waits, input logic [4:0] rd,
                             input logic [31:0] expect_data);
        int stalls;
        stalls = 0;
        @(negedge clk);
        drive(1'b1, addr, 32'h0, 1'b1, 1'b0, f3, rd, 1'b1);
        push(expect_data, rd, 1'b1, 1'b0, 1'b1);
        #1;
        if (mem_stall === 1'b1) stalls++;
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b0 || dmem_addr !== (addr & 32'hFFFF_FFFC)) begin
            errors++;
            $display("FAIL %s_req: req=%b we=%b addr=%h want 1/0/%h", name, dmem_req, dmem_we, dmem_addr, addr & 32'hFFFF_FFFC);
        end
        for (int i = 0; i < waits; i++) begin
            #1;
            if (mem_stall === 1'b1) stalls++;
            @(negedge clk);
        end
        dmem_ready = 1'b1;
        dmem_rdata = rdata;
        #1;
        if (mem_stall === 1'b1) stalls++;
        checks++;
        if (stalls != waits + 1) begin
            errors++;
            $display("FAIL %s_stall_cycles: got %0d want %0d", name, stalls, waits + 1);
        end
        @(negedge clk);
        dmem_ready = 1'b0;
        dmem_rdata = '0;
        ex_valid = 1'b0;
        checks++;
        if (dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_req_drop: dmem_req=%b want 0", name, dmem_req);
        end
    endtask

    task automatic test_store(input string name, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] sdata, input logic also_read,
                              input logic [3:0] exp_strb, input logic [31:0] exp_wdata);
        @(negedge clk);
        drive(1'b1, addr, sdata, also_read, 1'b1, f3, 5'd9, 1'b1);
        push(32'h0, 5'd9, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checks++;
        if (dmem_req !== 1'b1 || dmem_we !== 1'b1 || dmem_addr !== (addr & 32'hFFFF_FFFC) ||
            dmem_wstrb !== exp_strb || dmem_wdata !== exp_wdata) begin
            errors++;
            $display("FAIL %s_port: req=%b we=%b addr=%h strb=%b wdata=%h want 1/1/%h/%b/%h",
                     name, dmem_req, dmem_we, dmem_addr, dmem_wstrb, dmem_wdata,
                     addr & 32'hFFFF_FFFC, exp_strb, exp_wdata);
        end
        dmem_ready = 1'b1;
        #1;
        checks++;
        if (mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL %s_ready_stall: mem_stall=%b want 0", name, mem_stall);
        end
        @(negedge clk);
        dmem_ready = 1'b0;
        ex_valid = 1'b0;
    endtask

    task automatic test_misalign(input string name, input logic [2:0] f3, input logic [31:0] addr,
                                 input logic wr_en);
        @(negedge clk);
        drive(1'b1, addr, 32'hFFFF_FFFF, !wr_en, wr_en, f3, 5'd7, 1'b1);
        push(32'h0, 5'd7, 1'b0, 1'b1, 1'b0);
        #1;
        checks++;
        if (mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL %s_stall: mem_stall=%b want 0", name, mem_stall);
        end
        @(negedge clk);
        ex_valid = 1'b0;
        checks++;
        if (dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL %s_no_req: dmem_req=%b want 0", name, dmem_req);
        end
        @(negedge clk);
        checks++;
        if (misalign !== 1'b0) begin
            errors++;
            $display("FAIL %s_pulse: misalign=%b want 0 one cycle later", name, misalign);
        end
    endtask

    task automatic test_reset_in_access();
        @(negedge clk);
        drive(1'b1, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 3'b010, 5'd3, 1'b1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        ex_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (dmem_req !== 1'b0 || wb_valid !== 1'b0 || mem_stall !== 1'b0) begin
            errors++;
            $display("FAIL rst_access: req=%b wb_valid=%b stall=%b want 0/0/0", dmem_req, wb_valid, mem_stall);
        end
        dmem_ready = 1'b1;
        dmem_rdata = 32'h1111_1111;
        @(negedge clk);
        dmem_ready = 1'b0;
        checks++;
        if (wb_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_no_wb: wb_valid=%b want 0 after aborted access", wb_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] v;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            v = 32'hA000_0000 + 32'(i * 7 + 1);
            drive(1'b1, v, 32'h0, 1'b0, 1'b0, 3'b000, 5'(10 + i), i[0]);
            push(v, 5'(10 + i), i[0], 1'b0, 1'b1);
        end
        test_load("lhu_b2b", 3'b101, 32'h0000_0402, 32'hC3A5_0000, 0, 5'd20, 32'h0000_C3A5);
    endtask

`ifdef MEM_TIMEOUT_EN
    task automatic test_timeout();
        int n;
        n = 0;
        @(negedge clk);
        drive(1'b1, 32'h0000_0100, 32'h0, 1'b1, 1'b0, 3'b010, 5'd4, 1'b1);
        push(32'h0, 5'd4, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        #1;
        while (mem_stall === 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (n + 1 != 4) begin
            errors++;
            $display("FAIL timeout_cycles: access lasted %0d cycles want 4", n + 1);
        end
        @(negedge clk);
        ex_valid = 1'b0;
        checks++;
        if (bus_error !== 1'b1 || dmem_req !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse: bus_error=%b req=%b want 1/0", bus_error, dmem_req);
        end
        @(negedge clk);
        checks++;
        if (bus_error !== 1'b0) begin
            errors++;
            $display("FAIL timeout_pulse_len: bus_error=%b want 0", bus_error);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu_op();
        test_load("lb", 3'b000, 32'h0000_0103, 32'h80FF_0000, 3, 5'd1, 32'hFFFF_FF80);
        test_load("lbu", 3'b100, 32'h0000_0103, 32'h80FF_0000, 3, 5'd2, 32'h0000_0080);
        test_load("lh", 3'b001, 32'h0000_0102, 32'h80FF_0000, 1, 5'd3, 32'hFFFF_80FF);
        test_load("lhu", 3'b101, 32'h0000_0102, 32'h80FF_0000, 0, 5'd4, 32'h0000_80FF);
        test_load("lw", 3'b010, 32'h0000_0104, 32'hDEAD_BEEF, 0, 5'd6, 32'hDEAD_BEEF);
        test_load("l_f3_011", 3'b011, 32'h0000_0108, 32'h1357_9BDF, 2, 5'd8, 32'h1357_9BDF);
        test_load("lb_pos", 3'b000, 32'h0000_0101, 32'h0000_7F00, 0, 5'd11, 32'h0000_007F);
        test_store("sh", 3'b001, 32'h0000_0202, 32'hABCD_1234, 1'b0, 4'b1100, 32'h1234_1234);
        test_store("sb", 3'b000, 32'h0000_0001, 32'h0000_00AB, 1'b0, 4'b0010, 32'hABAB_ABAB);
        test_store("sw", 3'b010, 32'h0000_0300, 32'hCAFE_F00D, 1'b0, 4'b1111, 32'hCAFE_F00D);
        test_store("rw_both", 3'b000, 32'h0000_0013, 32'h0000_005A, 1'b1, 4'b1000, 32'h5A5A_5A5A);
        test_misalign("lw_mis", 3'b010, 32'h0000_0101, 1'b0);
        test_misalign("lh_mis", 3'b001, 32'h0000_0101, 1'b0);
        test_misalign("sh_mis", 3'b001, 32'h0000_0203, 1'b1);
        test_misalign("f3_111_mis", 3'b111, 32'h0000_0102, 1'b0);
        test_reset_in_access();
        test_back_to_back();
`ifdef MEM_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(negedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: %0d expected retirements never seen, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
